// File: rtl/color_classifier.sv
// color_classifier: picks the dominant channel of each TCS3200 measurement frame, debounces
// the choice over STABLE frames and drives the one-hot colour LEDs. A watchdog blanks the
// output and raises fault when frames stop arriving.
//
// Ports:
//   clk_50       system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   r_cnt/g_cnt/b_cnt  per-channel counts, valid while frame_valid is high
//   frame_valid  one-cycle strobe, one frame per cycle at most
//   led          committed colour: 100 red, 010 green, 001 blue, 000 none
//   color_valid  a decision has been committed since reset or the last fault
//   color_change one-cycle pulse whenever led changes
//   fault        watchdog expired, cleared by the next frame
//   frame_count  accepted frames, wraps at 16 bits
//
// Pipeline: capture (E) -> classify (E+1) -> debounce (E+2) -> outputs (E+3).
module color_classifier #(
  parameter int unsigned CW           = 32,
  parameter int unsigned MARGIN_SHIFT = 3,
  parameter int unsigned MIN_COUNT    = 64,
  parameter int unsigned STABLE       = 3,
  parameter int unsigned TIMEOUT      = 50_000_000
) (
  input  logic          clk_50,
  input  logic          rst,
  input  logic [CW-1:0] r_cnt,
  input  logic [CW-1:0] g_cnt,
  input  logic [CW-1:0] b_cnt,
  input  logic          frame_valid,
  output logic [2:0]    led,
  output logic          color_valid,
  output logic          color_change,
  output logic          fault,
  output logic [15:0]   frame_count
);

  localparam int unsigned AgreeW = $clog2(STABLE + 1);
  localparam int unsigned WdW    = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ColNone  = 3'b000;
  localparam logic [2:0] ColRed   = 3'b100;
  localparam logic [2:0] ColGreen = 3'b010;
  localparam logic [2:0] ColBlue  = 3'b001;

  // Stage 1: captured counts
  logic          s1_valid_q;
  logic [CW-1:0] s1_r_q, s1_g_q, s1_b_q;

  // Stage 2: classified candidate
  logic          s2_valid_q;
  logic [2:0]    s2_cand_q;

  // Stage 3: debounce state and pending commit
  logic [2:0]        pending_q, pending_d;
  logic [AgreeW-1:0] agree_q, agree_d;
  logic              commit_d;
  logic              s3_commit_q;
  logic [2:0]        s3_led_q;

  // Watchdog
  logic [WdW-1:0] wd_q;
  logic           timeout_hit;

  // Classification
  logic [CW-1:0] max_val, second_val, margin, diff;
  logic [2:0]    winner, cand;

  always_comb begin
    winner     = ColNone;
    max_val    = '0;
    second_val = '0;
    if (s1_r_q >= s1_g_q && s1_r_q >= s1_b_q) begin
      winner     = ColRed;
      max_val    = s1_r_q;
      second_val = (s1_g_q >= s1_b_q) ? s1_g_q : s1_b_q;
    end else if (s1_g_q >= s1_b_q) begin
      winner     = ColGreen;
      max_val    = s1_g_q;
      second_val = (s1_r_q >= s1_b_q) ? s1_r_q : s1_b_q;
    end else begin
      winner     = ColBlue;
      max_val    = s1_b_q;
      second_val = (s1_r_q >= s1_g_q) ? s1_r_q : s1_g_q;
    end
    margin = max_val >> MARGIN_SHIFT;
    // second_val never exceeds max_val, so this cannot wrap
    diff   = max_val - second_val;
    // a tie for the maximum gives diff == 0 and therefore falls out as none
    cand   = (max_val < CW'(MIN_COUNT) || diff <= margin) ? ColNone : winner;
  end

  always_comb begin
    pending_d = pending_q;
    agree_d   = agree_q;
    if (s2_cand_q == pending_q) begin
      if (agree_q != AgreeW'(STABLE)) begin
        agree_d = agree_q + AgreeW'(1);
      end
    end else begin
      pending_d = s2_cand_q;
      agree_d   = AgreeW'(1);
    end
    commit_d = (agree_d == AgreeW'(STABLE));
  end

  // A frame in the same cycle as expiry wins: no fault is raised.
  assign timeout_hit = !frame_valid && (wd_q == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk_50) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_r_q       <= '0;
      s1_g_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_cand_q    <= ColNone;
      pending_q    <= ColNone;
      agree_q      <= '0;
      s3_commit_q  <= 1'b0;
      s3_led_q     <= ColNone;
      wd_q         <= '0;
      led          <= ColNone;
      color_valid  <= 1'b0;
      color_change <= 1'b0;
      fault        <= 1'b0;
      frame_count  <= '0;
    end else begin
      color_change <= 1'b0;

      s1_valid_q <= frame_valid;
      if (frame_valid) begin
        s1_r_q      <= r_cnt;
        s1_g_q      <= g_cnt;
        s1_b_q      <= b_cnt;
        frame_count <= frame_count + 16'd1;
      end

      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_cand_q <= cand;
      end

      s3_commit_q <= s2_valid_q && commit_d;
      s3_led_q    <= pending_d;
      if (s2_valid_q) begin
        pending_q <= pending_d;
        agree_q   <= agree_d;
      end

      if (s3_commit_q) begin
        color_valid <= 1'b1;
        if (s3_led_q != led) begin
          led          <= s3_led_q;
          color_change <= 1'b1;
        end
      end

      if (frame_valid) begin
        wd_q  <= '0;
        fault <= 1'b0;
      end else if (wd_q != WdW'(TIMEOUT)) begin
        wd_q <= wd_q + WdW'(1);
      end

      // Expiry overrides any commit and drops frames still in the pipeline.
      if (timeout_hit) begin
        fault        <= 1'b1;
        led          <= ColNone;
        color_valid  <= 1'b0;
        color_change <= (led != ColNone);
        pending_q    <= ColNone;
        agree_q      <= '0;
        s2_valid_q   <= 1'b0;
        s3_commit_q  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/color_classifier.md
# color_classifier

Downstream decision stage for the TCS3200 colour front end. It takes one frame of per-channel measurement counts (red, green, blue), picks the dominant channel with a relative margin and an absolute floor, and debounces the decision over several frames. It drives the one-hot colour LEDs and status flags. A watchdog blanks the output and flags a fault when the sensor stops delivering frames.

## Interface
Parameters:
- CW, 32: width of each channel count.
- MARGIN_SHIFT, 3: winner must beat the runner-up by more than max>>MARGIN_SHIFT.
- MIN_COUNT, 64: a winner below this value is classified NONE.
- STABLE, 3: number of consecutive identical candidates required to commit a decision.
- TIMEOUT, 50_000_000: clock cycles without a frame before a fault is raised (1 s at 50 MHz).

Ports (one clock; reset is synchronous and active-high):
- clk_50, in, 1: system clock; all logic updates on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- r_cnt, in, CW: red channel count.
- g_cnt, in, CW: green channel count.
- b_cnt, in, CW: blue channel count.
- frame_valid, in, 1: one-cycle strobe; all three counts are valid in this cycle.
- led, out, 3: committed colour. 100 = red, 010 = green, 001 = blue, 000 = NONE.
- color_valid, out, 1: high once a decision has been committed since reset or since the last fault.
- color_change, out, 1: one-cycle pulse whenever led changes value.
- fault, out, 1: watchdog expired.
- frame_count, out, 16: number of accepted frames; wraps from 65535 to 0.

## Operation
- Reset values: led=000, color_valid=0, color_change=0, fault=0, frame_count=0. Internal state also resets: pending=NONE, agree=0, watchdog=0, and all pipeline valid bits are cleared.
- Stage 1 (capture): when frame_valid is high, register r/g/b and set s1_valid. frame_count increments by one.
- Stage 2 (classify):
  - Compute max, second and the winner channel.
  - margin = max >> MARGIN_SHIFT, computed at CW bits. diff = max − second; this cannot underflow.
  - candidate = NONE if max < MIN_COUNT or diff <= margin. Otherwise candidate = the winner's one-hot code.
  - Any tie for max therefore yields NONE.
  - Register candidate and set s2_valid.
- Stage 3 (debounce), on s2_valid:
  - If candidate == pending: agree = min(agree+1, STABLE).
  - Otherwise: pending = candidate, agree = 1.
  - When agree (new value) == STABLE: color_valid = 1. If pending != led, then led = pending and color_change pulses for one cycle.
  - NONE commits like any other colour.
- Watchdog:
  - The counter clears on every frame_valid and otherwise increments, saturating at TIMEOUT.
  - On reaching TIMEOUT: fault=1, led=000, color_valid=0, pending=NONE, agree=0.
  - color_change pulses if led was non-zero.
  - Frames already in flight in stages 2 and 3 are discarded.
- The next frame_valid clears fault in its sampling cycle. That frame then proceeds normally.
- Frames are accepted back-to-back, one per cycle. The pipeline never stalls and has no backpressure.

## Timing
- Latency: frame_valid is sampled at edge E. led and color_change update at edge E+3.
- color_change is high for exactly one cycle per led change.
- frame_count updates at edge E.
- Simultaneous events:
  - frame_valid in the same cycle that the watchdog reaches TIMEOUT: the frame wins. No fault is raised and the counter clears.
  - Fault assertion in the same cycle that stage 3 would commit: the fault wins and led=000.
- rst asserted mid-frame: all stages reset at that edge. The next frame is treated as the first.
- Counts are unsigned. No arithmetic stage exceeds CW bits.

## Test plan
Bench settings: STABLE=3, MARGIN_SHIFT=3, MIN_COUNT=64, TIMEOUT=1000 (overridden for simulation).
1. Reset check: hold rst for 2 cycles, then release. Required: all outputs zero. With no frames, fault asserts exactly 1000 cycles after reset release.
2. Red commit: three frames with r=1000, g=400, b=300.
   - Required: led=100, color_valid=1 and a single color_change pulse, all 3 cycles after the third frame_valid.
   - No change is allowed after the first or second frame.
3. Margin and floor:
   - Three frames r=1000, g=900, b=100 (diff 100 <= margin 125). Required: led stays 000, color_valid becomes 1, no color_change.
   - Three frames r=g=b=50. Required: NONE.
4. Debounce: frame sequence R, R, G, G, G with dominant counts as in test 2.
   - Required: led goes directly 000 → 010 after the fifth frame, with exactly one color_change.
   - Red is never committed.
5. Watchdog: commit blue, then send no frames for 1000 cycles.
   - Required: fault=1, led=000, color_valid=0, one color_change pulse.
   - A subsequent frame_valid clears fault. Three blue frames recommit led=001.
6. Back-to-back and wrap:
   - Preload frame_count to 65534 by sending frames, then issue 3 consecutive-cycle frames. Required: frame_count reads 1.
   - Assert rst during the second of three red frames. Required: no commit, and all outputs are zero after the reset edge.
